pc_fetch_ctrl: RTL and testbench

- Generates the fetch PC for the IF stage and drives the instruction-memory request handshake.
- Consumes the jump/branch redirect resolved in MEM, in the opposite direction to the MEM-stage link-value select (ALU result vs PC+4).
- On redirect it reloads the PC and flushes the younger instructions in IF, ID and EX.
- Exports pc_plus4 so that the link value travels down the pipeline to the MEM-stage select.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pc_fetch_ctrl_if.sv | 27 ++
 rtl/pc_redirect_arb.sv | 41 ++++
 rtl/pc_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch controller and the
// redirect arbiter.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    BUBBLE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus: instruction-memory request handshake plus the fetch PC
// bundle handed to the IF/ID register.
interface pc_fetch_ctrl_if;
  import pipe_pkg::*;

  logic            imem_req;
  logic            imem_ready;
  logic            instr_valid;
  logic [XLEN-1:0] pc_if;
  logic [XLEN-1:0] pc_plus4_if;

  modport master (
    output imem_req,
    output pc_if,
    output pc_plus4_if,
    output instr_valid,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  pc_if,
    input  pc_plus4_if,
    input  instr_valid,
    output imem_ready
  );
endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: merges the MEM-stage jump/branch
// resolution into one redirect, its target PC and the flush vector.
// Shared with the hazard unit so both see identical flush decisions.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned targets trap).
module pc_redirect_arb
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic            enable,
  input  logic            jump_mem,
  input  logic            branch_taken_mem,
  input  logic [XLEN-1:0] target_mem,
  output logic            redirect,
  output logic [XLEN-1:0] next_pc,
  output logic [2:0]      flush_vec,
  output logic            misalign
);

  // Jump and branch together still form a single redirect.
  assign redirect  = enable & (jump_mem | branch_taken_mem);
  // bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM
  assign flush_vec = {3{redirect}};

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |target_mem[1:0];
  assign next_pc    = misaligned ? TRAP_VECTOR : target_mem;
  assign misalign   = redirect & misaligned;
`else
  // Low target bits are dropped rather than trapped; the trap vector has
  // no consumer in this build.
  logic [1:0] unused_target_lsb;
  logic       unused_trap_vector;
  assign unused_target_lsb  = target_mem[1:0];
  assign unused_trap_vector = ^TRAP_VECTOR;
  assign next_pc            = {target_mem[XLEN-1:2], 2'b00};
  assign misalign           = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC generator and instruction-memory request controller.
// Optional feature macro: PC_MISALIGN_TRAP_EN (handled in pc_redirect_arb).
//
//   state  | meaning
//   BOOT   | first cycle after reset, no request, redirects ignored
//   FETCH  | imem_req high, PC advances on an accepted fetch
//   BUBBLE | imem_req low for REDIRECT_BUBBLES cycles after a redirect
module pc_fetch_ctrl
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR     = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR      = 32'h0000_0100,
  parameter int unsigned     REDIRECT_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             jump_mem,
  input  logic             branch_taken_mem,
  input  logic [XLEN-1:0]  target_mem,
  pc_fetch_ctrl_if.master  fetch,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             misalign_trap
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [2:0]      flush_vec;
  logic            imem_req;
  logic            instr_valid;
  logic [XLEN-1:0] pc_plus4;

  pc_redirect_arb #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_arb (
    .enable           (state_q != BOOT),
    .jump_mem         (jump_mem),
    .branch_taken_mem (branch_taken_mem),
    .target_mem       (target_mem),
    .redirect         (redirect),
    .next_pc          (redirect_pc),
    .flush_vec        (flush_vec),
    .misalign         (misalign_trap)
  );

  assign pc_plus4 = pc_q + INSTR_BYTES;

  // State, PC and bubble counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state / next PC; a redirect overrides stall and the imem handshake.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (fetch.imem_ready && !stall && !redirect) begin
          instr_valid = 1'b1;
          pc_d        = pc_plus4;
        end
      end
      BUBBLE: begin
        if (cnt_q <= 2'd1) begin
          state_d = FETCH;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = BOOT;
    endcase
    if (redirect) begin
      pc_d        = redirect_pc;
      cnt_d       = 2'(REDIRECT_BUBBLES);
      state_d     = (REDIRECT_BUBBLES > 0) ? BUBBLE : FETCH;
      instr_valid = 1'b0;
    end
  end

  assign fetch.imem_req    = imem_req;
  assign fetch.instr_valid = instr_valid;
  assign fetch.pc_if       = pc_q;
  assign fetch.pc_plus4_if = pc_plus4;
  assign flush_if_id       = flush_vec[0];
  assign flush_id_ex       = flush_vec[1];
  assign flush_ex_mem      = flush_vec[2];

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl with a per-cycle expectation queue.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_VEC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int          RB       = 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        req;
    logic        valid;
    logic [2:0]  flush;
    logic        trap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        jump_mem = 1'b0;
  logic        branch_taken_mem = 1'b0;
  logic [31:0] target_mem = 32'h0;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, misalign_trap;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  logic [31:0] m_pc   = RST_VEC;
  logic        m_boot = 1'b1;
  int          m_bub  = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(
    .RESET_VECTOR     (RST_VEC),
    .TRAP_VECTOR      (TRAP_VEC),
    .REDIRECT_BUBBLES (RB)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .jump_mem         (jump_mem),
    .branch_taken_mem (branch_taken_mem),
    .target_mem       (target_mem),
    .fetch            (bus),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .flush_ex_mem     (flush_ex_mem),
    .misalign_trap    (misalign_trap)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle (called at posedge+1), predict, compare at negedge,
  // then advance the model and return at the next posedge+1.
  task automatic step(input logic st, input logic j, input logic b,
                      input logic [31:0] tgt, input logic rdy);
    exp_t e, o;
    logic redir;
    logic [31:0] dest;
    stall = st; jump_mem = j; branch_taken_mem = b; target_mem = tgt;
    bus.imem_ready = rdy;
    redir   = !m_boot && (j || b);
    e.pc    = m_pc;
    e.pc4   = m_pc + 32'd4;
    e.req   = !m_boot && (m_bub == 0);
    e.valid = e.req && rdy && !st && !redir;
    e.flush = redir ? 3'b111 : 3'b000;
`ifdef PC_MISALIGN_TRAP_EN
    e.trap  = redir && (tgt[1:0] != 2'b00);
    dest    = (tgt[1:0] != 2'b00) ? TRAP_VEC : tgt;
`else
    e.trap  = 1'b0;
    dest    = {tgt[31:2], 2'b00};
`endif
    sb_q.push_back(e);
    @(negedge clk);
    o = sb_q.pop_front();
    check_val("pc_if",       bus.pc_if,       o.pc);
    check_val("pc_plus4_if", bus.pc_plus4_if, o.pc4);
    check_val("imem_req",    32'(bus.imem_req),    32'(o.req));
    check_val("instr_valid", 32'(bus.instr_valid), 32'(o.valid));
    check_val("flush_vec",   32'({flush_ex_mem, flush_id_ex, flush_if_id}), 32'(o.flush));
    check_val("misalign_trap", 32'(misalign_trap), 32'(o.trap));
    if (m_boot) m_boot = 1'b0;
    else if (redir) begin m_pc = dest; m_bub = RB; end
    else if (m_bub > 0) m_bub--;
    else if (e.valid) m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; jump_mem = 1'b0; branch_taken_mem = 1'b0; target_mem = 32'h0;
    bus.imem_ready = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_pc"},    bus.pc_if, RST_VEC);
    check_val({tag, "_req"},   32'(bus.imem_req), 32'd0);
    check_val({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check_val({tag, "_flush"}, 32'({flush_ex_mem, flush_id_ex, flush_if_id}), 32'd0);
    check_val({tag, "_trap"},  32'(misalign_trap), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = RST_VEC; m_boot = 1'b1; m_bub = 0;
  endtask

  initial begin
    int guard;
    clear_inputs();
    #3;
    check_reset_values("rst");
    release_reset();

    step(0, 0, 0, 0, 1);                       // BOOT
    step(0, 0, 0, 0, 1);                       // fetch 0x0
    step(0, 0, 0, 0, 1);                       // fetch 0x4
    repeat (4) step(0, 0, 0, 0, 0);            // imem not ready at 0x8
    step(0, 0, 0, 0, 1);                       // accept 0x8
    step(0, 0, 0, 0, 1);                       // accept 0xC
    check_val("at_0x10", bus.pc_if, 32'h10);
    repeat (3) step(1, 0, 0, 0, 1);            // stall holds 0x10
    step(0, 0, 0, 0, 1);
    check_val("after_stall", bus.pc_if, 32'h14);

    guard = 0;
    while (m_pc != 32'h40 && guard < 40) begin
      step(0, 0, 0, 0, 1);
      guard++;
    end
    check_val("reach_0x40", bus.pc_if, 32'h40);

    step(1, 1, 0, 32'h200, 1);                 // jump under stall
    check_val("jump_pc", bus.pc_if, 32'h200);
    step(0, 0, 0, 0, 1);                       // bubble
    step(0, 0, 0, 0, 1);                       // fetch 0x200

    step(0, 0, 1, 32'h202, 1);                 // misaligned branch
`ifdef PC_MISALIGN_TRAP_EN
    check_val("misalign_pc", bus.pc_if, TRAP_VEC);
`else
    check_val("misalign_pc", bus.pc_if, 32'h200);
`endif
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    step(0, 1, 1, 32'h300, 1);                 // jump and branch together
    step(0, 1, 0, 32'h400, 1);                 // redirect during bubble
    check_val("last_redirect_wins", bus.pc_if, 32'h400);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    step(0, 1, 0, 32'hFFFF_FFFC, 1);           // wrap-around
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_val("wrap_pc", bus.pc_if, 32'h0);
    step(0, 0, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end
    clear_inputs();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    step(0, 1, 0, 32'h80, 1);                  // enter BUBBLE, then reset
    clear_inputs();
    check_val("pre_rst_pc", bus.pc_if, 32'h80);
    check_val("pre_rst_req", 32'(bus.imem_req), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    release_reset();
    step(0, 0, 0, 0, 1);                       // BOOT again
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_val("reboot_pc", bus.pc_if, 32'h8);

    if (sb_q.size() != 0) check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
